// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kbd_pkg
//  Description : Shared definitions for the PS/2 scan-code sequencer.
//                Holds the PS/2 prefix/shift scan codes, the prefix-state
//                enum, the buffered key event record and small helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package kbd_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    // Prefix tracking: which of E0 / F0 have been seen for the event
    // currently being assembled.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } prefix_state_e;

    // One completed key event, 10 bits wide.
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } kbd_evt_t;

    // PS/2 frames carry odd parity over data plus parity bit.
    function automatic logic parity_ok(input logic [8:0] sc);
        return ^sc;
    endfunction

    function automatic logic is_shift(input logic [7:0] code);
        return (code == SC_LSHIFT) || (code == SC_RSHIFT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/kbd_evt_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : kbd_evt_fifo
//  Description : Synchronous FIFO holding completed key events.
//                Push is refused when full unless a pop happens in the same
//                cycle; a pop while empty is ignored. The head entry reads
//                as all-zero while the FIFO is empty.
//  Ports       : clk_i    - clock, rising edge
//                rst_ni   - synchronous active-low reset
//                push_i   - write data_i this cycle
//                data_i   - event to write
//                pop_i    - remove the head entry this cycle
//                data_o   - head entry (zero when empty)
//                full_o   - FIFO_DEPTH entries stored
//                empty_o  - no entries stored
//  Revision    : 1.0  initial release
// ============================================================================
module kbd_evt_fifo
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4   // power of two, at least 2
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  kbd_evt_t data_i,
    input  logic     pop_i,
    output kbd_evt_t data_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    kbd_evt_t      mem_q [FIFO_DEPTH];

    logic push_ok;
    logic pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_COUNT);

    assign pop_ok  = pop_i && !empty_o;
    // A pop frees a slot in the same edge, so a full FIFO can still accept.
    assign push_ok = push_i && (!full_o || pop_ok);

    // Pointers are power-of-two wide, so plain increment wraps modulo depth.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage needs no reset: it is only observed through a non-empty head.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/kbd_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : kbd_scan_sequencer
//  Description : Turns a stream of PS/2 scan bytes into key events.
//                Checks odd parity, folds E0/F0 prefixes into an
//                {ext, brk, code} event, tracks the shift keys and buffers
//                events in a FIFO for a ready/valid consumer.
//  Ports       : clk_i          - clock, rising edge
//                rst_ni         - synchronous active-low reset
//                scan_code_p_i  - [8] odd parity bit, [7:0] scan byte
//                valid_i        - scan_code_p_i offered this cycle
//                key_code_o     - head event scan code
//                key_ext_o      - head event had the E0 prefix
//                key_break_o    - head event is a release
//                key_valid_o    - buffer non-empty, head fields valid
//                key_ready_i    - consumer takes the head event
//                shift_held_o   - left or right shift currently pressed
//                parity_err_o   - one-cycle pulse after a rejected byte
//                overflow_o     - sticky, an event was dropped (buffer full)
//  Revision    : 1.0  initial release
// ============================================================================
module kbd_scan_sequencer
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4   // power of two, at least 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [8:0] scan_code_p_i,
    input  logic       valid_i,
    output logic [7:0] key_code_o,
    output logic       key_ext_o,
    output logic       key_break_o,
    output logic       key_valid_o,
    input  logic       key_ready_i,
    output logic       shift_held_o,
    output logic       parity_err_o,
    output logic       overflow_o
);

    prefix_state_e state_q, state_d;
    logic          shift_q, shift_d;
    logic          perr_q,  perr_d;
    logic          ovf_q,   ovf_d;

    logic          evt_push;
    kbd_evt_t      evt;
    kbd_evt_t      head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;

    logic [7:0]    scan_byte;

    assign scan_byte = scan_code_p_i[7:0];
    assign pop       = key_ready_i && !fifo_empty;

    // ------------------------------------------------------------------
    // Prefix FSM: next state and event assembly
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        evt_push = 1'b0;
        evt      = '0;
        perr_d   = 1'b0;

        if (valid_i) begin
            if (!parity_ok(scan_code_p_i)) begin
                // A corrupted byte also abandons any partial prefix.
                perr_d  = 1'b1;
                state_d = ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (scan_byte == SC_EXT) begin
                            state_d = ST_EXT;
                        end else if (scan_byte == SC_BREAK) begin
                            state_d = ST_BRK;
                        end else begin
                            evt_push = 1'b1;
                            evt      = '{ext: 1'b0, brk: 1'b0, code: scan_byte};
                        end
                    end
                    ST_EXT: begin
                        if (scan_byte == SC_EXT) begin
                            state_d = ST_EXT;
                        end else if (scan_byte == SC_BREAK) begin
                            state_d = ST_EXT_BRK;
                        end else begin
                            evt_push = 1'b1;
                            evt      = '{ext: 1'b1, brk: 1'b0, code: scan_byte};
                            state_d  = ST_IDLE;
                        end
                    end
                    ST_BRK, ST_EXT_BRK: begin
                        // A prefix byte after F0 is a protocol violation;
                        // restart decoding as if this byte arrived in IDLE.
                        if (scan_byte == SC_EXT) begin
                            state_d = ST_EXT;
                        end else if (scan_byte == SC_BREAK) begin
                            state_d = ST_BRK;
                        end else begin
                            evt_push = 1'b1;
                            evt      = '{ext: (state_q == ST_EXT_BRK),
                                         brk: 1'b1,
                                         code: scan_byte};
                            state_d  = ST_IDLE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Shift tracking and overflow flag
    // ------------------------------------------------------------------
    always_comb begin
        shift_d = shift_q;
        ovf_d   = ovf_q;

        // Shift state follows every completed event, even one the full
        // buffer drops, so it never disagrees with the physical keys.
        if (evt_push && !evt.ext && is_shift(evt.code)) begin
            shift_d = !evt.brk;
        end

        if (evt_push && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            shift_q <= 1'b0;
            perr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ovf_q   <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Event buffer
    // ------------------------------------------------------------------
    kbd_evt_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (evt_push),
        .data_i  (evt),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign key_valid_o  = !fifo_empty;
    assign key_code_o   = head.code;
    assign key_ext_o    = head.ext;
    assign key_break_o  = head.brk;
    assign shift_held_o = shift_q;
    assign parity_err_o = perr_q;
    assign overflow_o   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_kbd_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kbd_scan_sequencer
//  Description : Self-checking bench for kbd_scan_sequencer. A flag-based
//                reference model with an event queue predicts every output;
//                directed sequences add literal expectations, followed by a
//                randomized byte stream with random ready and resets.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_kbd_scan_sequencer;
    import kbd_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] scan = '0;
    logic       valid = 1'b0;
    logic       key_ready = 1'b0;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_valid;
    logic       shift_held;
    logic       parity_err;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    kbd_scan_sequencer #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .scan_code_p_i (scan),
        .valid_i       (valid),
        .key_code_o    (key_code),
        .key_ext_o     (key_ext),
        .key_break_o   (key_break),
        .key_valid_o   (key_valid),
        .key_ready_i   (key_ready),
        .shift_held_o  (shift_held),
        .parity_err_o  (parity_err),
        .overflow_o    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: pending-prefix flags plus a queue of events
    // ------------------------------------------------------------------
    kbd_evt_t mq[$];
    bit m_ext, m_brk, m_shift, m_ovf, m_perr;
    bit popped, have;
    kbd_evt_t ev;
    logic [7:0] b;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_ext = 0; m_brk = 0; m_shift = 0; m_ovf = 0; m_perr = 0;
        end else begin
            popped = key_ready && (mq.size() > 0);
            have   = 0;
            ev     = '0;
            b      = scan[7:0];
            m_perr = valid && !(^scan);
            if (valid) begin
                if (!(^scan)) begin
                    m_ext = 0; m_brk = 0;
                end else if (b == 8'hE0) begin
                    m_ext = 1; m_brk = 0;
                end else if (b == 8'hF0) begin
                    if (m_brk) m_ext = 0;
                    m_brk = 1;
                end else begin
                    have = 1;
                    ev.ext = m_ext; ev.brk = m_brk; ev.code = b;
                    m_ext = 0; m_brk = 0;
                end
            end
            if (popped) void'(mq.pop_front());
            if (have) begin
                if (mq.size() < DEPTH) mq.push_back(ev);
                else m_ovf = 1;
                if (!ev.ext && (ev.code == 8'h12 || ev.code == 8'h59))
                    m_shift = !ev.brk;
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("key_valid", key_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("key_code", key_code, mq[0].code);
                chk("key_ext", key_ext, mq[0].ext);
                chk("key_break", key_break, mq[0].brk);
            end else begin
                chk("key_code_empty", key_code, 0);
                chk("key_ext_empty", key_ext, 0);
                chk("key_break_empty", key_break, 0);
            end
            chk("shift_held", shift_held, m_shift);
            chk("parity_err", parity_err, m_perr);
            chk("overflow", overflow, m_ovf);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge)
    // ------------------------------------------------------------------
    task automatic drive(input logic v, input logic [7:0] byt, input logic badp, input logic rdy);
        valid     = v;
        scan      = {(~^byt) ^ badp, byt};
        key_ready = rdy;
    endtask

    task automatic step(input logic v, input logic [7:0] byt, input logic badp, input logic rdy);
        @(negedge clk);
        drive(v, byt, badp, rdy);
    endtask

    task automatic send(input logic [7:0] byt, input logic rdy);
        step(1'b1, byt, 1'b0, rdy);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 8'h00, 1'b0, rdy);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
        idle(1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle(1'b0);
        idle(1'b0);
        rst_n = 1'b1;
        check_en = 1'b1;
        idle(1'b0);
        chk("reset_key_valid", key_valid, 0);
        chk("reset_overflow", overflow, 0);

        // Single make code consumed immediately.
        send(8'h1C, 1'b1);
        idle(1'b1);
        chk("single_valid", key_valid, 1);
        chk("single_code", key_code, 8'h1C);
        idle(1'b1);
        chk("single_valid_one_cycle", key_valid, 0);

        // Break and extended-break sequences.
        send(8'hF0, 1'b0); send(8'h1C, 1'b0);
        send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
        idle(1'b0);
        chk("brk_head", {key_ext, key_break, key_code}, {2'b01, 8'h1C});
        idle(1'b1);
        idle(1'b0);
        chk("extbrk_head", {key_ext, key_break, key_code}, {2'b11, 8'h75});
        drain();

        // Shift tracking.
        send(8'h12, 1'b0);
        send(8'h32, 1'b0);
        chk("shift_set", shift_held, 1);
        send(8'hF0, 1'b0); send(8'h12, 1'b0);
        idle(1'b0);
        chk("shift_clear", shift_held, 0);
        drain();

        // Parity errors.
        step(1'b1, 8'h1C, 1'b1, 1'b0);
        idle(1'b0);
        chk("perr_pulse", parity_err, 1);
        chk("perr_no_event", key_valid, 0);
        idle(1'b0);
        chk("perr_one_cycle", parity_err, 0);
        send(8'hE0, 1'b0);
        step(1'b1, 8'h33, 1'b1, 1'b0);
        send(8'h74, 1'b0);
        idle(1'b0);
        chk("perr_resets_prefix", {key_ext, key_break, key_code}, {2'b00, 8'h74});
        drain();

        // Overflow and push/pop at full.
        send(8'h15, 1'b0); send(8'h16, 1'b0); send(8'h1E, 1'b0);
        send(8'h26, 1'b0); send(8'h25, 1'b0);
        idle(1'b0);
        chk("ovf_set", overflow, 1);
        chk("ovf_head", key_code, 8'h15);
        send(8'h36, 1'b1);
        idle(1'b0);
        chk("full_pushpop_head", key_code, 8'h16);
        drain();

        // Reset mid-prefix.
        send(8'hE0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_zero", {key_valid, key_code, key_ext, key_break, shift_held, parity_err, overflow}, 0);
        rst_n = 1'b1;
        drive(1'b1, 8'h74, 1'b0, 1'b0);
        idle(1'b0);
        chk("rst_discards_prefix", {key_ext, key_break, key_code}, {2'b00, 8'h74});
        drain();

        // Randomized stream.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] rb;
            case ($urandom_range(0, 5))
                0: rb = 8'hE0;
                1: rb = 8'hF0;
                2: rb = 8'h12;
                3: rb = 8'h59;
                default: rb = 8'($urandom_range(0, 255));
            endcase
            @(negedge clk);
            rst_n = ($urandom_range(0, 299) != 0);
            drive($urandom_range(0, 3) != 0, rb, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 2) == 0);
        end
        rst_n = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kbd_scan_sequencer.md
KBD_SCAN_SEQUENCER -- requirements
Module: kbd_scan_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, event buffer depth in entries, power of two, minimum 2.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 scan_code_p  input  9  bit 8 = odd-parity bit, bits 7:0 = PS/2 scan byte.
REQ-005 valid  input  1  one scan byte offered per cycle high; no backpressure on input.
REQ-006 key_code  output  8  head-of-buffer key scan code.
REQ-007 key_ext  output  1  head event carried the E0 extended prefix.
REQ-008 key_break  output  1  head event is a release (F0 prefix); 0 = press.
REQ-009 key_valid  output  1  buffer non-empty; head fields valid.
REQ-010 key_ready  input  1  consumer accepts head when key_valid & key_ready.
REQ-011 shift_held  output  1  left or right shift currently pressed.
REQ-012 parity_err  output  1  one-cycle pulse on a rejected byte.
REQ-013 overflow  output  1  sticky; an event was dropped because the buffer was full.

Function
REQ-014 Byte accepted only when valid=1 and ^scan_code_p==1 (odd parity); otherwise parity_err SHALL pulse the next cycle, byte discarded, prefix FSM returns to IDLE.
REQ-015 Prefix FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0).
REQ-016 IDLE: E0 -> EXT; F0 -> BRK; other -> complete event {ext=0, brk=0}, stay IDLE.
REQ-017 EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> event {1,0}, IDLE.
REQ-018 BRK: other than E0/F0 -> event {0,1}, IDLE; E0 or F0 -> protocol violation, treat as fresh prefix from IDLE.
REQ-019 EXT_BRK: other than E0/F0 -> event {1,1}, IDLE; E0 or F0 -> treat as fresh prefix from IDLE.
REQ-020 Completed event SHALL be pushed the same edge; key_valid visible one cycle after the completing byte's valid cycle.
REQ-021 shift_held: set on non-ext make of 8'h12 or 8'h59, cleared on non-ext break of either; updated the edge the event completes, independent of buffer full.
REQ-022 Buffer FIFO ordering; head fields stable while key_valid=1 and key_ready=0.
REQ-023 Push when full without same-cycle pop: event dropped, overflow set; push and pop in same cycle when full: both succeed.
REQ-024 Pop when empty ignored; key_ready ignored when key_valid=0.
REQ-025 Occupancy count width clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-026 rst_n=0 at a rising edge: FSM IDLE, buffer empty, key_valid=0, key_code=0, key_ext=0, key_break=0, shift_held=0, parity_err=0, overflow=0.
REQ-027 Reset mid-prefix (e.g. after E0) SHALL discard the partial sequence; overflow cleared only by reset.

Structure
REQ-028 Package kbd_pkg SHALL hold SC_EXT=8'hE0, SC_BREAK=8'hF0, SC_LSHIFT=8'h12, SC_RSHIFT=8'h59, the prefix-state enum, and the 10-bit event struct {ext, brk, code}.
REQ-029 Buffer SHALL be one sub-module kbd_evt_fifo (synchronous FIFO, push/pop/full/empty); FSM, parity and shift tracking in the top.

Verification
REQ-030 Bytes 1C (parity 0) with key_ready=1 -> one event key_code=1C, ext=0, brk=0, key_valid high exactly one cycle.
REQ-031 F0, 1C then E0, F0, 75 -> events {0,1,1C} then {1,1,75} in order; no event for prefix bytes.
REQ-032 12 make, 32 make, 12 break -> shift_held 1 after first event, 0 after third; 3 events buffered with key_ready=0.
REQ-033 1C with bit 8 flipped -> parity_err pulse, no event; E0 then bad-parity byte then 74 -> event {0,0,74}.
REQ-034 key_ready=0, FIFO_DEPTH+1 make events 15,16,1E,26,25 -> first 4 retained in order, overflow=1; simultaneous push/pop at full -> no drop.
REQ-035 E0 then rst_n low one cycle then 74 -> event {0,0,74}, all outputs zero during reset.
